// File: rtl/mult_seq_nbit.sv
// mult_seq_nbit: WIDTH-bit shift-add multiplier (signed/unsigned), ports clk/rst, Start/Signed/A/B in, Busy/Done/Result/ResultHigh/Overflow out
module mult_seq_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHigh,
  output logic             Overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t             state_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q, sgn_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic               ovf;
  always_comb begin
    mag_a = (Signed && A[WIDTH-1]) ? -A : A;
    mag_b = (Signed && B[WIDTH-1]) ? -B : B;
    prod  = neg_q ? -acc_q : acc_q;
    ovf   = sgn_q ? !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]))
                  : |prod[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      sgn_q      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Result     <= '0;
      ResultHigh <= '0;
      Overflow   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            sgn_q    <= Signed;
            neg_q    <= Signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            Busy     <= 1'b1;
            state_q  <= CALC;
          end else begin
            state_q  <= IDLE;
          end
        end
        CALC: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          {ResultHigh, Result} <= prod;
          Overflow <= ovf;
          Busy     <= 1'b0;
          Done     <= 1'b1;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_seq_nbit.sv
// tb_mult_seq_nbit: scoreboard bench for mult_seq_nbit at WIDTH=8 and WIDTH=16
module tb_mult_seq_nbit;
  logic clk = 0, rst = 1;
  logic st8 = 0, sg8 = 0, busy8, done8, ovf8;
  logic [7:0] a8 = 0, b8 = 0, lo8, hi8;
  logic st16 = 0, sg16 = 0, busy16, done16, ovf16;
  logic [15:0] a16 = 0, b16 = 0, lo16, hi16;
  int checks = 0, failures = 0, cyc = 0;
  logic [32:0] qv8[$], qv16[$];
  int qc8[$], qc16[$];

  mult_seq_nbit #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .Start(st8), .Signed(sg8), .A(a8), .B(b8),
    .Busy(busy8), .Done(done8), .Result(lo8), .ResultHigh(hi8), .Overflow(ovf8));
  mult_seq_nbit #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .Start(st16), .Signed(sg16), .A(a16), .B(b16),
    .Busy(busy16), .Done(done16), .Result(lo16), .ResultHigh(hi16), .Overflow(ovf16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input int w, input logic [15:0] a, input logic [15:0] b, input bit s);
    longint sa, sb, p, lo;
    logic o;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa -= longint'(1) << w;
    if (s && b[w-1]) sb -= longint'(1) << w;
    p  = sa * sb;
    o  = s ? (p < -(longint'(1) << (w - 1)) || p >= (longint'(1) << (w - 1))) : (p >= (longint'(1) << w));
    lo = p & ((longint'(1) << (2 * w)) - 1);
    return {o, lo[31:0]};
  endfunction

  always @(negedge clk) if (!rst && done8) begin
    chk("busy_in_done8", busy8, 0);
    if (qv8.size() == 0) chk("spurious_done8", 1, 0);
    else begin
      logic [32:0] m;
      m = qv8.pop_front();
      chk("prod8", {ovf8, hi8, lo8}, {m[32], m[15:0]});
      chk("lat8", cyc, qc8.pop_front());
    end
  end

  always @(negedge clk) if (!rst && done16) begin
    if (qv16.size() == 0) chk("spurious_done16", 1, 0);
    else begin
      chk("prod16", {ovf16, hi16, lo16}, qv16.pop_front());
      chk("lat16", cyc, qc16.pop_front());
    end
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit s, input bit push);
    a8 = a; b8 = b; sg8 = s; st8 = 1;
    @(posedge clk); #1;
    st8 = 0;
    if (push) begin
      qv8.push_back(model(8, {8'h0, a}, {8'h0, b}, s));
      qc8.push_back(cyc + 9);
    end
    chk("busy_after_accept8", busy8, 1);
  endtask

  task automatic go16(input logic [15:0] a, input logic [15:0] b, input bit s);
    a16 = a; b16 = b; sg16 = s; st16 = 1;
    @(posedge clk); #1;
    st16 = 0;
    qv16.push_back(model(16, a, b, s));
    qc16.push_back(cyc + 17);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && (qv8.size() + qv16.size()) != 0; i++) @(negedge clk);
    chk("drain", qv8.size() + qv16.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_zero8(input string tag);
    chk(tag, {busy8, done8, ovf8, hi8, lo8}, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero8("reset_state8");
    chk("reset_state16", {busy16, done16, ovf16, hi16, lo16}, 0);
    rst = 0;
    go8(15, 17, 0, 1);    drain(30);
    go8(200, 3, 0, 1);    drain(30);
    go8(255, 255, 0, 1);  drain(30);
    go8(8'hFD, 5, 1, 1);  drain(30);
    go8(8'h80, 1, 1, 1);  drain(30);
    go8(8'h80, 8'h80, 1, 1); drain(30);
    go8(0, 8'hAB, 0, 1);  drain(30);
    go8(15, 17, 0, 1);
    @(posedge clk); #1;
    a8 = 99; b8 = 7; st8 = 1;
    @(posedge clk); #1;
    st8 = 0;
    repeat (2) @(posedge clk);
    #1;
    a8 = 3; b8 = 200; sg8 = 1; st8 = 1;
    @(posedge clk); #1;
    st8 = 0;
    drain(30);
    a8 = 20; b8 = 30; sg8 = 0; st8 = 1;
    @(posedge clk); #1;
    qv8.push_back(model(8, 16'd20, 16'd30, 0));
    qc8.push_back(cyc + 9);
    a8 = 7; b8 = 9;
    repeat (10) @(posedge clk);
    #1;
    st8 = 0;
    qv8.push_back(model(8, 16'd7, 16'd9, 0));
    qc8.push_back(cyc + 9);
    drain(30);
    go8(100, 100, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check_zero8("abort_reset8");
    repeat (12) @(posedge clk);
    #1;
    chk("no_done_after_abort", {busy8, done8}, 0);
    go8(9, 9, 0, 1);      drain(30);
    go16(16'h8000, 16'h8000, 1); drain(40);
    go16(16'hFFFF, 16'hFFFF, 0); drain(40);
    for (int i = 0; i < 200; i++) begin
      go16(16'($urandom), 16'($urandom), 1'($urandom));
      drain(40);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
